// File: rtl/kbd_mmio_if.sv
// kbd_mmio_if: CPU data-memory port seen by the keyboard responder
interface kbd_mmio_if;
  logic [29:0] dmem_addr;
  logic        dmem_read_in;
  logic        dmem_write_in;
  logic [31:0] data_from_reg;
  logic [31:0] kbd_data_out;
  modport master (output dmem_addr, dmem_read_in, dmem_write_in, data_from_reg, input kbd_data_out);
  modport slave  (input dmem_addr, dmem_read_in, dmem_write_in, data_from_reg, output kbd_data_out);
endinterface

// File: rtl/kbd_mmio_responder.sv
// kbd_mmio_responder: PS/2 keyboard receiver with scan-code FIFO on the 0xe MMIO region
// Optional KBD_IRQ_EN adds a registered kbd_irq = nonempty | overflow output.
module kbd_mmio_responder #(
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
`ifdef KBD_IRQ_EN
  output logic kbd_irq,
`endif
  kbd_mmio_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] ck_s, dt_s;
  logic prev_clk, fall, dat, timeout, frame_ok, frame_perr, push_q;
  logic [2:0] bitcnt;
  logic [7:0] sh;
  logic par;
  logic [TW-1:0] tmo;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic overflow, parity_err, nonempty, full, pop, push_ok, clr;
  logic hit, wp, wc, wp_q, wc_q;
  logic [1:0] off;
  logic [31:0] status;
  logic unused_ok;
  assign unused_ok = ^{bus.data_from_reg, bus.dmem_addr[25:2]};
  assign fall = prev_clk & ~ck_s[SYNC_STAGES-1];
  assign dat = dt_s[SYNC_STAGES-1];
  assign timeout = (state != IDLE) && (tmo == TW'(TIMEOUT_CYCLES));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ck_s <= '1;
      dt_s <= '1;
      prev_clk <= 1'b1;
    end else begin
      ck_s <= {ck_s[SYNC_STAGES-2:0], ps2_clk};
      dt_s <= {dt_s[SYNC_STAGES-2:0], ps2_data};
      prev_clk <= ck_s[SYNC_STAGES-1];
    end
  always_comb begin
    state_n = state;
    frame_ok = 1'b0;
    frame_perr = 1'b0;
    if (timeout) state_n = IDLE;
    else if (fall)
      case (state)
        IDLE:    state_n = dat ? IDLE : DATA;
        DATA:    state_n = (bitcnt == 3'd7) ? PARITY : DATA;
        PARITY:  state_n = STOP;
        default: begin
          state_n = IDLE;
          frame_ok = dat & (^{sh, par});
          frame_perr = ~(^{sh, par});
        end
      endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      bitcnt <= '0;
      sh <= '0;
      par <= 1'b0;
      tmo <= '0;
      push_q <= 1'b0;
    end else begin
      state <= state_n;
      push_q <= frame_ok;
      tmo <= (state == IDLE || fall) ? '0 : tmo + 1'b1;
      if (fall && state == IDLE) bitcnt <= '0;
      if (fall && state == DATA) begin
        sh <= {dat, sh[7:1]};
        bitcnt <= bitcnt + 3'd1;
      end
      if (fall && state == PARITY) par <= dat;
    end
  assign hit = bus.dmem_addr[29:26] == 4'he;
  assign off = bus.dmem_addr[1:0];
  assign wp = hit & bus.dmem_write_in & (off == 2'd2);
  assign wc = hit & bus.dmem_write_in & (off == 2'd3);
  assign clr = wc & ~wc_q;
  assign nonempty = count != '0;
  assign full = count == (AW+1)'(FIFO_DEPTH);
  assign pop = wp & ~wp_q & nonempty;
  // a full FIFO still accepts the byte when a pop frees a slot in the same cycle
  assign push_ok = push_q & (~full | pop);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp_q <= 1'b0;
      wc_q <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      wp_q <= wp;
      wc_q <= wc;
      if (clr) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count <= '0;
        overflow <= 1'b0;
        parity_err <= 1'b0;
      end else begin
        rd_ptr <= rd_ptr + AW'(pop);
        wr_ptr <= wr_ptr + AW'(push_ok);
        count <= count + (AW+1)'(push_ok) - (AW+1)'(pop);
        overflow <= overflow | (push_q & ~push_ok);
        parity_err <= parity_err | frame_perr;
      end
    end
  always_ff @(posedge clk)
    if (push_ok && !clr) mem[wr_ptr] <= sh;
  assign status = {16'd0, 8'(count), 5'd0, parity_err, overflow, nonempty};
  assign bus.kbd_data_out = !(hit && bus.dmem_read_in) ? 32'd0 :
                            off == 2'd0 ? status :
                            (off == 2'd1 && nonempty) ? {24'd0, mem[rd_ptr]} : 32'd0;
`ifdef KBD_IRQ_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) kbd_irq <= 1'b0;
    else kbd_irq <= nonempty | overflow;
`endif
endmodule

// File: tb/tb_kbd_mmio_responder.sv
// tb_kbd_mmio_responder: directed checks of MMIO reads, strobes, FIFO and PS/2 framing
module tb_kbd_mmio_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] r;
`ifdef KBD_IRQ_EN
  logic kbd_irq;
`endif
  kbd_mmio_if bus();
  kbd_mmio_responder #(.FIFO_DEPTH(16), .TIMEOUT_CYCLES(200), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .rst(rst),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
`ifdef KBD_IRQ_EN
    .kbd_irq(kbd_irq),
`endif
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %h exp %h", tag, got, exp);
  endtask
  task automatic rd(input logic [3:0] rg, input logic [1:0] off, output logic [31:0] v);
    @(negedge clk);
    bus.dmem_addr = {rg, 24'd0, off};
    bus.dmem_read_in = 1'b1;
    #1 v = bus.kbd_data_out;
    bus.dmem_read_in = 1'b0;
  endtask
  task automatic wr(input logic [1:0] off, input int cycles);
    @(negedge clk);
    bus.dmem_addr = {4'he, 24'd0, off};
    bus.dmem_write_in = 1'b1;
    bus.data_from_reg = 32'hffff_ffff;
    repeat (cycles) @(negedge clk);
    bus.dmem_write_in = 1'b0;
    repeat (2) @(negedge clk);
  endtask
  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (4) @(posedge clk);
    ps2_clk = 1'b0;
    repeat (4) @(posedge clk);
    ps2_clk = 1'b1;
  endtask
  task automatic frame(input logic [7:0] d, input logic par, input logic stp);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(par);
    ps2_bit(stp);
    ps2_data = 1'b1;
    repeat (6) @(posedge clk);
  endtask
  task automatic good(input logic [7:0] d);
    frame(d, ~^d, 1'b1);
  endtask
  initial begin
    bus.dmem_addr = '0;
    bus.dmem_read_in = 1'b0;
    bus.dmem_write_in = 1'b0;
    bus.data_from_reg = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    rd(4'he, 2'd0, r); check("reset_status", r, 32'h0);
    rd(4'he, 2'd1, r); check("reset_data", r, 32'h0);
    rd(4'hc, 2'd0, r); check("reset_other_region", r, 32'h0);
    good(8'h1c);
    rd(4'he, 2'd0, r); check("1c_status", r, 32'h0000_0101);
    rd(4'he, 2'd1, r); check("1c_data", r, 32'h0000_001c);
    rd(4'hc, 2'd1, r); check("miss_region_data", r, 32'h0);
    rd(4'he, 2'd2, r); check("read_pop_offset", r, 32'h0);
`ifdef KBD_IRQ_EN
    check("irq_set", {31'd0, kbd_irq}, 32'd1);
`endif
    wr(2'd0, 1);
    rd(4'he, 2'd0, r); check("write_status_noeffect", r, 32'h0000_0101);
    good(8'h32);
    rd(4'he, 2'd0, r); check("two_status", r, 32'h0000_0201);
    wr(2'd2, 5);
    rd(4'he, 2'd0, r); check("held_pop_status", r, 32'h0000_0101);
    rd(4'he, 2'd1, r); check("held_pop_data", r, 32'h0000_0032);
    wr(2'd2, 1);
    rd(4'he, 2'd0, r); check("empty_status", r, 32'h0);
    rd(4'he, 2'd1, r); check("empty_data", r, 32'h0);
`ifdef KBD_IRQ_EN
    check("irq_clear", {31'd0, kbd_irq}, 32'd0);
`endif
    wr(2'd2, 1);
    rd(4'he, 2'd0, r); check("pop_empty_status", r, 32'h0);
    for (int i = 0; i < 17; i++) good(8'h40 + 8'(i));
    rd(4'he, 2'd0, r); check("overflow_status", r, 32'h0000_1003);
    rd(4'he, 2'd1, r); check("overflow_head", r, 32'h0000_0040);
    wr(2'd2, 1);
    rd(4'he, 2'd1, r); check("second_head", r, 32'h0000_0041);
    wr(2'd3, 3);
    rd(4'he, 2'd0, r); check("clear_status", r, 32'h0);
    rd(4'he, 2'd1, r); check("clear_data", r, 32'h0);
    good(8'h5a);
    rd(4'he, 2'd1, r); check("after_clear_head", r, 32'h0000_005a);
    wr(2'd3, 1);
    frame(8'h1c, 1'b1, 1'b1);
    rd(4'he, 2'd0, r); check("parity_err_status", r, 32'h0000_0004);
    wr(2'd3, 1);
    frame(8'h1c, 1'b0, 1'b0);
    rd(4'he, 2'd0, r); check("stop_err_status", r, 32'h0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_data = 1'b1;
    repeat (260) @(posedge clk);
    good(8'hf0);
    rd(4'he, 2'd0, r); check("timeout_status", r, 32'h0000_0101);
    rd(4'he, 2'd1, r); check("timeout_data", r, 32'h0000_00f0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
